// File: rtl/geri_yaz_denetleyici_pkg.sv
// Shared constants and payload types for the write-back controller.
package geri_yaz_denetleyici_pkg;

    // Long-latency source indices.
    localparam int unsigned KAYNAK_BOL                = 0;
    localparam int unsigned KAYNAK_BELLEK             = 1;
    localparam int unsigned VARSAYILAN_KAYNAK_SAYISI  = 2;
    localparam int unsigned VARSAYILAN_ACLIK_ESIGI    = 8;

    localparam int unsigned MESGUL_GENISLIK = 32;
    localparam int unsigned ADRES_GENISLIK  = 5;
    localparam int unsigned DEGER_GENISLIK  = 32;

    // Register-file write payload.
    typedef struct packed {
        logic                        yazmac;
        logic [ADRES_GENISLIK-1:0]   adres;
        logic [DEGER_GENISLIK-1:0]   deger;
    } yaz_istegi_t;

endpackage

// File: rtl/geri_yaz_denetleyici_rr_hakem.sv
// K-wide round-robin arbiter; search starts at the pointer, pointer moves past the winner on ilerlet.
module geri_yaz_denetleyici_rr_hakem #(
    parameter int unsigned K = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [K-1:0]                         istek_i,
    input  logic                                 ilerlet_i,
    output logic [K-1:0]                         izin_c,
    output logic [((K > 1) ? $clog2(K) : 1)-1:0] kazanan_c
);

    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;

    logic [IW-1:0] isaretci_q;
    logic [IW-1:0] isaretci_d;
    logic [IW-1:0] aday;
    logic          bulundu;

    // First requester at or after the pointer, wrapping modulo K.
    always_comb begin
        izin_c    = '0;
        kazanan_c = '0;
        bulundu   = 1'b0;
        aday      = '0;
        for (int unsigned i = 0; i < K; i++) begin
            aday = IW'((32'(isaretci_q) + i) % K);
            if (!bulundu && istek_i[aday]) begin
                bulundu       = 1'b1;
                izin_c[aday]  = 1'b1;
                kazanan_c     = aday;
            end
        end
    end

    // Next pointer: winner+1 mod K; with K=1 this is always 0.
    always_comb begin
        isaretci_d = isaretci_q;
        if (ilerlet_i) begin
            if (32'(kazanan_c) == K - 1)
                isaretci_d = '0;
            else
                isaretci_d = IW'(32'(kazanan_c) + 32'd1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) isaretci_q <= '0;
        else       isaretci_q <= isaretci_d;
    end

endmodule

// File: rtl/geri_yaz_denetleyici.sv
// Write-back controller: owns the register-file write port, tracks in-flight long results.
module geri_yaz_denetleyici
    import geri_yaz_denetleyici_pkg::*;
#(
    parameter int unsigned KAYNAK_SAYISI = VARSAYILAN_KAYNAK_SAYISI,
    parameter int unsigned ACLIK_ESIGI   = VARSAYILAN_ACLIK_ESIGI
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      yrt_yaz_i,
    input  logic [ADRES_GENISLIK-1:0]                 yrt_rd_adres_i,
    input  logic [DEGER_GENISLIK-1:0]                 yrt_rd_deger_i,
    input  logic [KAYNAK_SAYISI-1:0]                  uzun_gecerli_i,
    input  logic [ADRES_GENISLIK*KAYNAK_SAYISI-1:0]   uzun_rd_adres_i,
    input  logic [DEGER_GENISLIK*KAYNAK_SAYISI-1:0]   uzun_deger_i,
    output logic [KAYNAK_SAYISI-1:0]                  uzun_hazir_o,
    input  logic                                      coz_basla_i,
    input  logic [ADRES_GENISLIK-1:0]                 coz_basla_adres_i,
    output logic [MESGUL_GENISLIK-1:0]                cyo_mesgul_o,
    output logic                                      cyo_durdur_o,
    output logic                                      cyo_yaz_yazmac_o,
    output logic [ADRES_GENISLIK-1:0]                 cyo_yaz_adres_o,
    output logic [DEGER_GENISLIK-1:0]                 cyo_yaz_deger_o
);

    localparam int unsigned K  = KAYNAK_SAYISI;
    localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned SW = $clog2(ACLIK_ESIGI + 1);

    logic [K-1:0]                istek;
    logic [K-1:0]                izin;
    logic [IW-1:0]               kazanan;
    logic                        uzun_verildi;
    logic [ADRES_GENISLIK-1:0]   uzun_adres [K];
    logic [DEGER_GENISLIK-1:0]   uzun_deger [K];

    yaz_istegi_t                 yaz_q, yaz_d;
    logic [MESGUL_GENISLIK-1:0]  mesgul_q, mesgul_d;
    logic [SW-1:0]               aclik_q [K];
    logic [SW-1:0]               aclik_d [K];
    logic                        durdur_q, durdur_d;

    // YURUT always wins; reset withdraws every long request.
    assign istek        = (rst_i || yrt_yaz_i) ? '0 : uzun_gecerli_i;
    assign uzun_verildi = |izin;
    assign uzun_hazir_o = izin;

    geri_yaz_denetleyici_rr_hakem #(.K(K)) u_rr_hakem (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .istek_i   (istek),
        .ilerlet_i (uzun_verildi),
        .izin_c    (izin),
        .kazanan_c (kazanan)
    );

    // Split the flat per-unit buses into indexable arrays.
    always_comb begin
        for (int k = 0; k < int'(K); k++) begin
            uzun_adres[k] = uzun_rd_adres_i[k*ADRES_GENISLIK +: ADRES_GENISLIK];
            uzun_deger[k] = uzun_deger_i[k*DEGER_GENISLIK +: DEGER_GENISLIK];
        end
    end

    // Next write-port payload, scoreboard and starvation state.
    always_comb begin
        yaz_d    = '0;
        mesgul_d = mesgul_q;
        durdur_d = 1'b0;

        if (yrt_yaz_i) begin
            yaz_d.yazmac = (yrt_rd_adres_i != '0);
            yaz_d.adres  = yrt_rd_adres_i;
            yaz_d.deger  = yrt_rd_deger_i;
        end else if (uzun_verildi) begin
            yaz_d.yazmac = (uzun_adres[kazanan] != '0);
            yaz_d.adres  = uzun_adres[kazanan];
            yaz_d.deger  = uzun_deger[kazanan];
        end

        // Clear first so a same-edge set of the same rd survives.
        if (uzun_verildi)
            mesgul_d[uzun_adres[kazanan]] = 1'b0;
        if (coz_basla_i && (coz_basla_adres_i != '0))
            mesgul_d[coz_basla_adres_i] = 1'b1;

        for (int k = 0; k < int'(K); k++) begin
            aclik_d[k] = '0;
            if (uzun_gecerli_i[k] && !izin[k]) begin
                if (aclik_q[k] == SW'(ACLIK_ESIGI))
                    aclik_d[k] = aclik_q[k];
                else
                    aclik_d[k] = aclik_q[k] + SW'(1);
            end
            // Stall holds while a saturated unit is still waiting.
            if (uzun_gecerli_i[k] && !izin[k] && (aclik_q[k] == SW'(ACLIK_ESIGI)))
                durdur_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            yaz_q    <= '0;
            mesgul_q <= '0;
            durdur_q <= 1'b0;
            for (int k = 0; k < int'(K); k++) aclik_q[k] <= '0;
        end else begin
            yaz_q    <= yaz_d;
            mesgul_q <= mesgul_d;
            durdur_q <= durdur_d;
            for (int k = 0; k < int'(K); k++) aclik_q[k] <= aclik_d[k];
        end
    end

    assign cyo_mesgul_o     = mesgul_q;
    assign cyo_durdur_o     = durdur_q;
    assign cyo_yaz_yazmac_o = yaz_q.yazmac;
    assign cyo_yaz_adres_o  = yaz_q.adres;
    assign cyo_yaz_deger_o  = yaz_q.deger;

endmodule

// File: tb/tb_geri_yaz_denetleyici.sv
// Directed bench for the write-back controller (K=2, threshold 8).
module tb_geri_yaz_denetleyici;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        yrt_yaz;
    logic [4:0]  yrt_adres;
    logic [31:0] yrt_deger;
    logic [1:0]  uzun_gecerli;
    logic [9:0]  uzun_adres;
    logic [63:0] uzun_deger;
    logic [1:0]  uzun_hazir;
    logic        coz_basla;
    logic [4:0]  coz_adres;
    logic [31:0] mesgul;
    logic        durdur;
    logic        yaz_yazmac;
    logic [4:0]  yaz_adres;
    logic [31:0] yaz_deger;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    geri_yaz_denetleyici #(.KAYNAK_SAYISI(2), .ACLIK_ESIGI(8)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .yrt_yaz_i         (yrt_yaz),
        .yrt_rd_adres_i    (yrt_adres),
        .yrt_rd_deger_i    (yrt_deger),
        .uzun_gecerli_i    (uzun_gecerli),
        .uzun_rd_adres_i   (uzun_adres),
        .uzun_deger_i      (uzun_deger),
        .uzun_hazir_o      (uzun_hazir),
        .coz_basla_i       (coz_basla),
        .coz_basla_adres_i (coz_adres),
        .cyo_mesgul_o      (mesgul),
        .cyo_durdur_o      (durdur),
        .cyo_yaz_yazmac_o  (yaz_yazmac),
        .cyo_yaz_adres_o   (yaz_adres),
        .cyo_yaz_deger_o   (yaz_deger)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        yrt_yaz = 0; yrt_adres = '0; yrt_deger = '0;
        uzun_gecerli = '0; uzun_adres = '0; uzun_deger = '0;
        coz_basla = 0; coz_adres = '0;

        // Reset values
        rst = 1'b1;
        #2;
        chk("rst_yaz",    64'(yaz_yazmac), 64'd0);
        chk("rst_mesgul", 64'(mesgul),     64'd0);
        chk("rst_durdur", 64'(durdur),     64'd0);
        chk("rst_adres",  64'(yaz_adres),  64'd0);
        chk("rst_deger",  64'(yaz_deger),  64'd0);
        tick(); tick();
        rst = 1'b0;

        // YURUT priority over two valid long units
        yrt_yaz = 1; yrt_adres = 5'd5; yrt_deger = 32'hDEADBEEF;
        uzun_gecerli = 2'b11;
        uzun_adres = {5'd4, 5'd3};
        uzun_deger = {32'h2222_2222, 32'h1111_1111};
        #1;
        chk("yrt_hazir", 64'(uzun_hazir), 64'b00);
        tick();
        chk("yrt_yaz",   64'(yaz_yazmac), 64'd1);
        chk("yrt_adres", 64'(yaz_adres),  64'd5);
        chk("yrt_deger", 64'(yaz_deger),  64'hDEADBEEF);

        // Round robin, pointer at 0: 01,10,01,10
        yrt_yaz = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("rr_hazir", 64'(uzun_hazir), (c % 2 == 0) ? 64'b01 : 64'b10);
            tick();
            chk("rr_adres", 64'(yaz_adres), (c % 2 == 0) ? 64'd3 : 64'd4);
            chk("rr_deger", 64'(yaz_deger), (c % 2 == 0) ? 64'h1111_1111 : 64'h2222_2222);
        end
        chk("rr_durdur", 64'(durdur), 64'd0);

        // Scoreboard set then clear on rd=7 (pointer 0 -> 1 after grant)
        uzun_gecerli = 2'b00;
        coz_basla = 1; coz_adres = 5'd7;
        tick();
        chk("sb_set", 64'(mesgul), 64'h80);
        coz_basla = 0;
        uzun_gecerli = 2'b01; uzun_adres = {5'd4, 5'd7}; uzun_deger = {32'h0, 32'hA5A5_0007};
        #1;
        chk("sb_clr_hazir", 64'(uzun_hazir), 64'b01);
        tick();
        chk("sb_clr", 64'(mesgul), 64'h0);
        chk("sb_clr_adres", 64'(yaz_adres), 64'd7);
        chk("sb_clr_deger", 64'(yaz_deger), 64'hA5A5_0007);

        // Same-edge set and clear of rd=7: set wins
        uzun_gecerli = 2'b00; coz_basla = 1; coz_adres = 5'd7;
        tick();
        uzun_gecerli = 2'b01;
        #1;
        chk("race_hazir", 64'(uzun_hazir), 64'b01);
        tick();
        chk("race_mesgul", 64'(mesgul), 64'h80);

        // x0: no scoreboard set, grant without write
        uzun_gecerli = 2'b00; coz_adres = 5'd0;
        tick();
        chk("x0_mesgul", 64'(mesgul), 64'h80);
        chk("x0_idle_yaz", 64'(yaz_yazmac), 64'd0);
        coz_basla = 0;
        uzun_gecerli = 2'b01; uzun_adres = {5'd4, 5'd0};
        #1;
        chk("x0_hazir", 64'(uzun_hazir), 64'b01);
        tick();
        chk("x0_yaz", 64'(yaz_yazmac), 64'd0);
        chk("x0_mesgul2", 64'(mesgul), 64'h80);

        // Starvation: YURUT every cycle, unit 1 blocked
        uzun_gecerli = 2'b10; uzun_adres = {5'd12, 5'd0}; uzun_deger = {32'hC0DE_0012, 32'h0};
        yrt_yaz = 1; yrt_adres = 5'd1; yrt_deger = 32'h1;
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk("st_hazir", 64'(uzun_hazir), 64'b00);
            tick();
        end
        chk("st_durdur8", 64'(durdur), 64'd0);
        chk("st_yrt_yaz", 64'(yaz_yazmac), 64'd1);
        tick();
        chk("st_durdur9", 64'(durdur), 64'd1);

        // Release: unit 1 granted, durdur drops at the following edge
        yrt_yaz = 0;
        #1;
        chk("rel_hazir", 64'(uzun_hazir), 64'b10);
        tick();
        chk("rel_durdur", 64'(durdur), 64'd0);
        chk("rel_yaz",    64'(yaz_yazmac), 64'd1);
        chk("rel_adres",  64'(yaz_adres),  64'd12);
        chk("rel_deger",  64'(yaz_deger),  64'hC0DE_0012);

        // Move pointer to 1 with a unit-0 grant
        uzun_gecerli = 2'b01; uzun_adres = {5'd12, 5'd2};
        tick();

        // Reset mid-grant
        uzun_gecerli = 2'b11; coz_basla = 1; coz_adres = 5'd3;
        #1;
        chk("pre_rst_hazir", 64'(uzun_hazir), 64'b10);
        rst = 1'b1;
        #1;
        chk("mrst_hazir",  64'(uzun_hazir), 64'b00);
        chk("mrst_yaz",    64'(yaz_yazmac), 64'd0);
        chk("mrst_mesgul", 64'(mesgul),     64'd0);
        chk("mrst_durdur", 64'(durdur),     64'd0);
        tick();
        rst = 1'b0;
        uzun_gecerli = 2'b00; coz_basla = 0;
        tick();
        chk("post_rst_yaz",    64'(yaz_yazmac), 64'd0);
        chk("post_rst_mesgul", 64'(mesgul),     64'd0);
        uzun_gecerli = 2'b11;
        #1;
        chk("post_rst_ptr", 64'(uzun_hazir), 64'b01);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
